cpu_mem_responder: RTL and testbench

- Memory-side responder for the 8-bit CPU's fetch and load/store traffic.
- Holds a single-port array of 16-bit words and serves two kinds of access through a valid/ready request channel and a valid/ready response channel:
  - word instruction fetches;
  - byte-granular data loads and stores, using the same byte addressing as the CPU (word index = byte address >> 1, odd byte = [15:8], even byte = [7:0]).
- A host programming port preloads the program while the CPU side is stalled.

---
 rtl/cpu_mem_responder.sv | 112 +++++++++++
 tb/tb_cpu_mem_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Memory responder for the 8-bit CPU. It serves word fetches and byte loads/stores
// from one 16-bit word array, one access per request/response handshake.
module cpu_mem_responder #(
  parameter int MEMORY_SIZE = 32,
  parameter int WORD_AW     = $clog2(MEMORY_SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic               req_byte,
  input  logic [7:0]         req_addr,
  input  logic [7:0]         req_wdata,
  output logic               rsp_valid,
  output logic [15:0]        rsp_data,
  input  logic               rsp_ready,
  output logic               rsp_err,
  input  logic               host_en,
  input  logic               host_we,
  input  logic [WORD_AW-1:0] host_addr,
  input  logic [15:0]        host_wdata
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [8:0]       CPU_LIM  = 9'(MEMORY_SIZE);
  localparam logic [WORD_AW:0] HOST_LIM = (WORD_AW+1)'(MEMORY_SIZE);

  state_t state, state_nxt;

  logic [15:0] mem [MEMORY_SIZE];

  logic [7:0]         idx_full_p0;
  logic [WORD_AW-1:0] idx_p0;
  logic               lane_p0;
  logic               in_range_p0;
  logic               acc_p0;
  logic               err_p0;
  logic               store_p0;
  logic               load_p0;
  logic               host_wr_p0;

  logic [15:0] rsp_data_p1;
  logic        rsp_err_p1;

  function automatic logic [7:0] lane_sel(input logic [15:0] word, input logic lane);
    return lane ? word[15:8] : word[7:0];
  endfunction

  function automatic logic [15:0] rd_fmt(input logic [15:0] word, input logic byte_acc,
                                         input logic lane);
    return byte_acc ? {8'h00, lane_sel(word, lane)} : word;
  endfunction

  // Request decode (p0): the request is accepted, the array accessed and the response
  // registered on the same edge.
  assign req_ready = (state == IDLE) && !host_en && !rst;

  always_comb begin
    idx_full_p0 = req_byte ? {1'b0, req_addr[7:1]} : req_addr;
    idx_p0      = idx_full_p0[WORD_AW-1:0];
    lane_p0     = req_addr[0];
    in_range_p0 = {1'b0, idx_full_p0} < CPU_LIM;
    acc_p0      = req_valid && req_ready;
    // A word-sized store is not a legal CPU request; it is reported as an error.
    err_p0      = !in_range_p0 || (req_write && !req_byte);
    store_p0    = acc_p0 && req_write && req_byte && in_range_p0;
    load_p0     = acc_p0 && !req_write && in_range_p0;
    host_wr_p0  = (state == IDLE) && host_en && host_we && ({1'b0, host_addr} < HOST_LIM);
  end

  // The array has a single port and is never reset, so a host preload survives a CPU reset.
  // CPU stores and host writes cannot coincide because host_en blocks acceptance.
  always_ff @(posedge clk) begin
    if (store_p0) begin
      if (lane_p0) mem[idx_p0][15:8] <= req_wdata;
      else         mem[idx_p0][7:0]  <= req_wdata;
    end else if (host_wr_p0) begin
      mem[host_addr] <= host_wdata;
    end
  end

  // Response register (p1): held stable while the response waits in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data_p1 <= '0;
      rsp_err_p1  <= 1'b0;
    end else if (acc_p0) begin
      rsp_err_p1  <= err_p0;
      rsp_data_p1 <= load_p0 ? rd_fmt(mem[idx_p0], req_byte, lane_p0) : 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (acc_p0)    state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign rsp_data  = rsp_data_p1;
  assign rsp_err   = rsp_err_p1;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder. Expected responses are queued when a request
// is driven and compared when the response appears.
module tb_cpu_mem_responder;

  localparam int MEMORY_SIZE = 32;
  localparam int WORD_AW     = $clog2(MEMORY_SIZE);

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid, req_ready, req_write, req_byte;
  logic [7:0]         req_addr, req_wdata;
  logic               rsp_valid, rsp_ready, rsp_err;
  logic [15:0]        rsp_data;
  logic               host_en, host_we;
  logic [WORD_AW-1:0] host_addr;
  logic [15:0]        host_wdata;

  typedef struct packed {
    logic [15:0] d;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  cpu_mem_responder #(.MEMORY_SIZE(MEMORY_SIZE), .WORD_AW(WORD_AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
    .host_en(host_en), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [WORD_AW-1:0] a, input logic [15:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    step();
    host_we = 1'b0;
  endtask

  // Drive one request, wait (bounded) for acceptance, then compare the response.
  task automatic send(input logic w, input logic b, input logic [7:0] a, input logic [7:0] wd,
                      input logic [15:0] ed, input logic ee, input string tag);
    exp_t e;
    int   n;
    e.d = ed;
    e.e = ee;
    sb.push_back(e);
    req_valid = 1'b1; req_write = w; req_byte = b; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    check({tag, "_accept"}, 16'(req_ready), 16'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      void'(sb.pop_back());
      return;
    end
    step();
    req_valid = 1'b0;
    check({tag, "_rsp_valid"}, 16'(rsp_valid), 16'd1);
    check({tag, "_busy"}, 16'(req_ready), 16'd0);
    check({tag, "_sb_nonempty"}, 16'(sb.size()), 16'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_data"}, rsp_data, e.d);
      check({tag, "_err"}, 16'(rsp_err), 16'(e.e));
    end
  endtask

  task automatic complete(input logic exp_rdy, input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_done_valid"}, 16'(rsp_valid), 16'd0);
    check({tag, "_done_ready"}, 16'(req_ready), 16'(exp_rdy));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    host_en = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

    // Reset state
    step(); step();
    check("rst_valid", 16'(rsp_valid), 16'd0);
    check("rst_data", rsp_data, 16'h0000);
    check("rst_err", 16'(rsp_err), 16'd0);
    check("rst_ready", 16'(req_ready), 16'd0);
    rst = 1'b0;
    #1;
    check("idle_ready", 16'(req_ready), 16'd1);

    // Host preload
    host_en = 1'b1;
    #1;
    check("host_blocks_ready", 16'(req_ready), 16'd0);
    host_write(5'd0, 16'h4105);
    host_write(5'd3, 16'hBEEF);
    host_en = 1'b0;
    #1;
    send(1'b0, 1'b0, 8'd3, 8'h00, 16'hBEEF, 1'b0, "fetch3");
    complete(1'b1, "fetch3");

    // Byte lanes and read-after-store
    send(1'b0, 1'b1, 8'd6, 8'h00, 16'h00EF, 1'b0, "rdb6");
    complete(1'b1, "rdb6");
    send(1'b0, 1'b1, 8'd7, 8'h00, 16'h00BE, 1'b0, "rdb7");
    complete(1'b1, "rdb7");
    send(1'b1, 1'b1, 8'd7, 8'h12, 16'h0000, 1'b0, "stb7");
    complete(1'b1, "stb7");
    send(1'b0, 1'b0, 8'd3, 8'h00, 16'h12EF, 1'b0, "fetch3_new");
    complete(1'b1, "fetch3_new");

    // Backpressure
    send(1'b0, 1'b0, 8'd0, 8'h00, 16'h4105, 1'b0, "bp");
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_hold_valid", 16'(rsp_valid), 16'd1);
      check("bp_hold_data", rsp_data, 16'h4105);
      check("bp_hold_ready", 16'(req_ready), 16'd0);
    end
    complete(1'b1, "bp");

    // Out of range and illegal word store
    send(1'b1, 1'b1, 8'd64, 8'hAA, 16'h0000, 1'b1, "oor_store");
    complete(1'b1, "oor_store");
    send(1'b0, 1'b0, 8'd40, 8'h00, 16'h0000, 1'b1, "oor_fetch");
    complete(1'b1, "oor_fetch");
    send(1'b1, 1'b0, 8'd3, 8'h55, 16'h0000, 1'b1, "word_store");
    complete(1'b1, "word_store");
    send(1'b0, 1'b0, 8'd0, 8'h00, 16'h4105, 1'b0, "oor_w0_intact");
    complete(1'b1, "oor_w0_intact");
    send(1'b0, 1'b0, 8'd3, 8'h00, 16'h12EF, 1'b0, "oor_w3_intact");
    complete(1'b1, "oor_w3_intact");

    // Host arbitration
    send(1'b0, 1'b0, 8'd0, 8'h00, 16'h4105, 1'b0, "arb");
    host_en = 1'b1;
    step();
    check("arb_rsp_held", 16'(rsp_valid), 16'd1);
    check("arb_rsp_data", rsp_data, 16'h4105);
    complete(1'b0, "arb");
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 8'd5;
    #1;
    check("arb_stall_ready", 16'(req_ready), 16'd0);
    host_write(5'd5, 16'hCAFE);
    check("arb_stall_ready2", 16'(req_ready), 16'd0);
    check("arb_no_accept", 16'(rsp_valid), 16'd0);
    host_en = 1'b0;
    #1;
    send(1'b0, 1'b0, 8'd5, 8'h00, 16'hCAFE, 1'b0, "arb_fetch5");
    complete(1'b1, "arb_fetch5");

    // Reset mid-response
    send(1'b0, 1'b0, 8'd3, 8'h00, 16'h12EF, 1'b0, "rstmid");
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_valid", 16'(rsp_valid), 16'd0);
    check("rstmid_data", rsp_data, 16'h0000);
    check("rstmid_err", 16'(rsp_err), 16'd0);
    #1;
    check("rstmid_ready", 16'(req_ready), 16'd1);
    send(1'b0, 1'b0, 8'd0, 8'h00, 16'h4105, 1'b0, "post_rst_w0");
    complete(1'b1, "post_rst_w0");
    send(1'b0, 1'b1, 8'd7, 8'h00, 16'h0012, 1'b0, "post_rst_b7");
    complete(1'b1, "post_rst_b7");

    check("sb_drained", 16'(sb.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
